// File: rtl/icache_line_fill.sv
// icache_line_fill: direct-mapped I-cache with whole-line fill, halfword-aligned (line-straddling) fetch and flush
// Optional feature: define ICACHE_PERF_CNT_EN to add perf_hit_cnt/perf_miss_cnt outputs.
module icache_line_fill #(
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        IF_query_en,
    input  logic [31:0] IF_query_addr,
    output logic        IF_dout_en,
    output logic [31:0] IF_dout,
    output logic        MC_query_en,
    output logic [31:0] MC_query_addr,
    input  logic        MC_data_en,
    input  logic [31:0] MC_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt
`endif
);
    localparam int TAG_WIDTH = 30 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int WORDS     = 1 << OFFSET_WIDTH;
    localparam int TAG_LO    = INDEX_WIDTH + OFFSET_WIDTH + 2;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                  state;
    logic [LINES-1:0]        valid;
    logic [TAG_WIDTH-1:0]    tag_arr [LINES];
    logic [31:0]             data_arr [LINES*WORDS];
    logic                    flush_pend;
    logic [OFFSET_WIDTH-1:0] cnt;
    logic [TAG_WIDTH-1:0]    fill_tag;
    logic [INDEX_WIDTH-1:0]  fill_idx;

    logic [31:0]             addr_a, addr_b, word_a, word_b;
    logic [TAG_WIDTH-1:0]    tag_a, tag_b, miss_tag;
    logic [INDEX_WIDTH-1:0]  idx_a, idx_b, miss_idx;
    logic [OFFSET_WIDTH-1:0] off_a, off_b;
    logic                    hit_a, hit_b, hit, accept, fill_we;
    logic [2:0]              unused_bits;

    // The low halfword comes from A, the high one from A+2 (wraps mod 2^32, may sit in the next line)
    assign addr_a      = {IF_query_addr[31:1], 1'b0};
    assign addr_b      = addr_a + 32'd2;
    assign tag_a       = addr_a[31:TAG_LO];
    assign tag_b       = addr_b[31:TAG_LO];
    assign idx_a       = addr_a[TAG_LO-1:OFFSET_WIDTH+2];
    assign idx_b       = addr_b[TAG_LO-1:OFFSET_WIDTH+2];
    assign off_a       = addr_a[OFFSET_WIDTH+1:2];
    assign off_b       = addr_b[OFFSET_WIDTH+1:2];
    assign word_a      = data_arr[{idx_a, off_a}];
    assign word_b      = data_arr[{idx_b, off_b}];
    assign hit_a       = valid[idx_a] && tag_arr[idx_a] == tag_a;
    assign hit_b       = valid[idx_b] && tag_arr[idx_b] == tag_b;
    assign hit         = hit_a && hit_b && !flush_in;
    assign miss_tag    = (hit_a && !flush_in) ? tag_b : tag_a;
    assign miss_idx    = (hit_a && !flush_in) ? idx_b : idx_a;
    assign accept      = state == IDLE && IF_query_en && !IF_dout_en;
    assign fill_we     = rst_n_in && rdy_in && state == FILL && MC_query_en && MC_data_en;
    assign unused_bits = {IF_query_addr[0], addr_a[0], addr_b[0]};

    // Control FSM: hit response, line fill sequencing, valid bits and deferred flush
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            valid         <= '0;
            IF_dout_en    <= 1'b0;
            IF_dout       <= '0;
            MC_query_en   <= 1'b0;
            MC_query_addr <= '0;
            flush_pend    <= 1'b0;
            cnt           <= '0;
            fill_tag      <= '0;
            fill_idx      <= '0;
        end else if (rdy_in) begin
            IF_dout_en <= 1'b0;
            if (flush_in)
                valid <= '0;
            if (state == IDLE) begin
                if (accept && hit) begin
                    IF_dout_en <= 1'b1;
                    IF_dout    <= {addr_b[1] ? word_b[31:16] : word_b[15:0],
                                   addr_a[1] ? word_a[31:16] : word_a[15:0]};
                end else if (accept) begin
                    state         <= FILL;
                    fill_tag      <= miss_tag;
                    fill_idx      <= miss_idx;
                    cnt           <= '0;
                    MC_query_en   <= 1'b1;
                    MC_query_addr <= {miss_tag, miss_idx, {OFFSET_WIDTH{1'b0}}, 2'b00};
                end
            end else begin
                if (flush_in)
                    flush_pend <= 1'b1;
                if (!MC_query_en) begin
                    MC_query_en   <= 1'b1;
                    MC_query_addr <= {fill_tag, fill_idx, cnt, 2'b00};
                end else if (MC_data_en) begin
                    MC_query_en <= 1'b0;
                    cnt         <= cnt + 1'b1;
                    if (&cnt) begin
                        state           <= IDLE;
                        flush_pend      <= 1'b0;
                        valid[fill_idx] <= !(flush_pend || flush_in);
                    end
                end
            end
        end
    end

    // Line storage: not reset, its contents are only trusted through the valid bits
    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            data_arr[{fill_idx, cnt}] <= MC_data;
            if (&cnt)
                tag_arr[fill_idx] <= fill_tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Hit counter counts responses, miss counter counts fill entries
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
        end else if (rdy_in) begin
            perf_hit_cnt  <= perf_hit_cnt + {31'd0, accept && hit};
            perf_miss_cnt <= perf_miss_cnt + {31'd0, accept && !hit};
        end
    end
`endif
endmodule

// File: tb/tb_icache_line_fill.sv
// tb_icache_line_fill: randomized scoreboard bench for icache_line_fill against a line-level cache model
module tb_icache_line_fill;
    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        flush_in = 1'b0;
    logic        IF_query_en = 1'b0;
    logic [31:0] IF_query_addr = '0;
    logic        IF_dout_en;
    logic [31:0] IF_dout;
    logic        MC_query_en;
    logic [31:0] MC_query_addr;
    logic        MC_data_en = 1'b0;
    logic [31:0] MC_data = '0;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

    int          checks = 0;
    int          fails = 0;
    logic [31:0] resp_q[$];
    logic [31:0] mc_q[$];
    logic [31:0] last_resp = '0;
    bit          mc_enable = 1'b0;
    bit          flush_arm = 1'b0;
    logic [31:0] flush_addr = '0;
    bit          valid_m[16];
    logic [31:0] line_m[16];

    icache_line_fill dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .rdy_in(rdy_in),
        .flush_in(flush_in),
        .IF_query_en(IF_query_en),
        .IF_query_addr(IF_query_addr),
        .IF_dout_en(IF_dout_en),
        .IF_dout(IF_dout),
        .MC_query_en(MC_query_en),
        .MC_query_addr(MC_query_addr),
        .MC_data_en(MC_data_en),
        .MC_data(MC_data)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .perf_hit_cnt(perf_hit_cnt),
        .perf_miss_cnt(perf_miss_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem({a[31:2], 2'b00});
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit line_hit(input logic [31:0] la);
        return valid_m[la[7:4]] && line_m[la[7:4]] == la;
    endfunction

    function automatic int model_line(input logic [31:0] la);
        if (line_hit(la))
            return 0;
        for (int k = 0; k < 4; k++)
            mc_q.push_back(la + 32'(4 * k));
        valid_m[la[7:4]] = 1'b1;
        line_m[la[7:4]] = la;
        return 1;
    endfunction

    function automatic void model_clear();
        foreach (valid_m[i])
            valid_m[i] = 1'b0;
    endfunction

    // mode 0: plain fetch, 1: flush in the issue cycle, 2: flush during word 2 of the first fill
    task automatic issue(input logic [31:0] a, input int mode, output bit exp_hit);
        logic [31:0] aa, la, lb, first;
        int n;
        n  = 0;
        aa = {a[31:1], 1'b0};
        la = aa & ~32'hF;
        lb = (aa + 32'd2) & ~32'hF;
        if (mode == 1)
            model_clear();
        if (mode == 2) begin
            first = line_hit(la) ? lb : la;
            if (!line_hit(first)) begin
                n += model_line(first);
                model_clear();
                flush_arm  = 1'b1;
                flush_addr = first + 32'd8;
            end
        end
        n += model_line(la);
        n += model_line(lb);
        exp_hit = (n == 0);
        resp_q.push_back({hw(aa + 32'd2), hw(aa)});
        IF_query_addr = a;
        IF_query_en   = 1'b1;
        flush_in      = (mode == 1);
    endtask

    task automatic wait_resp(input int mode, input bit chk_lat);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk_in);
            cyc++;
            if (mode == 1 && cyc == 1) begin
                check("flush_hit_suppressed", {31'd0, IF_dout_en}, 32'd0);
                flush_in = 1'b0;
            end
        end while (!IF_dout_en && cyc < 400);
        if (!IF_dout_en)
            check("resp_timeout", {31'd0, IF_dout_en}, 32'd1);
        IF_query_en = 1'b0;
        if (chk_lat)
            check("hit_latency", cyc, 32'd1);
        check("fills_done", mc_q.size(), 32'd0);
    endtask

    task automatic fetch(input logic [31:0] a, input int mode);
        bit h;
        @(negedge clk_in);
        issue(a, mode, h);
        wait_resp(mode, h);
    endtask

    task automatic do_flush();
        @(negedge clk_in);
        flush_in = 1'b1;
        @(negedge clk_in);
        flush_in = 1'b0;
        model_clear();
    endtask

    // Scoreboard monitor: every IF response is matched against the oldest expected fetch
    initial begin
        forever begin
            @(negedge clk_in);
            if (IF_dout_en) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL resp_unexpected: got %h expected none", IF_dout);
                end else begin
                    last_resp = resp_q.pop_front();
                    check("if_dout", IF_dout, last_resp);
                end
            end
        end
    end

    // Memory controller model: random latency, checks request order, hold and the one-cycle gap
    initial begin
        logic [31:0] a;
        int d;
        forever begin
            @(negedge clk_in);
            if (mc_enable && MC_query_en) begin
                a = MC_query_addr;
                if (mc_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL mc_unexpected: got %h expected none", a);
                end else
                    check("mc_addr", a, mc_q.pop_front());
                if (flush_arm && a == flush_addr) begin
                    flush_in = 1'b1;
                    @(negedge clk_in);
                    flush_in  = 1'b0;
                    flush_arm = 1'b0;
                end
                d = $urandom_range(0, 3);
                repeat (d) @(negedge clk_in);
                if (d > 0)
                    check("mc_hold", MC_query_addr, a);
                MC_data    = mem(a);
                MC_data_en = 1'b1;
                @(negedge clk_in);
                MC_data_en = 1'b0;
                MC_data    = $urandom;
                check("mc_gap", {31'd0, MC_query_en}, 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        int r, mode, cyc;
        logic [31:0] base, a;
        model_clear();
        repeat (3) @(negedge clk_in);
        check("rst_if_dout_en", {31'd0, IF_dout_en}, 32'd0);
        check("rst_if_dout", IF_dout, 32'd0);
        check("rst_mc_query_en", {31'd0, MC_query_en}, 32'd0);
        check("rst_mc_query_addr", MC_query_addr, 32'd0);
        rst_n_in  = 1'b1;
        mc_enable = 1'b1;

        fetch(32'h0000_1000, 0);
        fetch(32'h0000_1002, 0);
        fetch(32'h0000_100E, 0);
        fetch(32'hFFFF_FFFE, 0);
        fetch(32'h0000_2004, 2);
        fetch(32'h0000_2004, 0);
        fetch(32'h0000_1002, 0);
        do_flush();
        fetch(32'h0000_1002, 0);
        fetch(32'h0000_1002, 1);
        fetch(32'h0000_1002, 0);

        do_flush();
        mc_enable = 1'b0;
        @(negedge clk_in);
        issue(32'h0000_5008, 0, h);
        cyc = 0;
        do begin
            @(negedge clk_in);
            cyc++;
        end while (!MC_query_en && cyc < 10);
        rdy_in   = 1'b0;
        flush_in = 1'b1;
        repeat (5) begin
            @(negedge clk_in);
            flush_in = 1'b0;
            check("stall_mc_en", {31'd0, MC_query_en}, 32'd1);
            check("stall_mc_addr", MC_query_addr, 32'h0000_5000);
            check("stall_if_en", {31'd0, IF_dout_en}, 32'd0);
            check("stall_if_dout", IF_dout, last_resp);
        end
        rdy_in    = 1'b1;
        mc_enable = 1'b1;
        wait_resp(0, 1'b0);
        fetch(32'h0000_5008, 0);
        @(negedge clk_in);
        issue(32'h0000_500A, 0, h);
        rdy_in   = 1'b0;
        flush_in = 1'b1;
        repeat (5) begin
            @(negedge clk_in);
            flush_in = 1'b0;
            check("stall_idle_if_en", {31'd0, IF_dout_en}, 32'd0);
        end
        rdy_in = 1'b1;
        wait_resp(0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            r    = $urandom_range(0, 3);
            base = r == 0 ? 32'h0000_1000 : r == 1 ? 32'h0000_2000 : r == 2 ? 32'hFFFF_FFC0 : 32'h0000_3040;
            a    = base + 32'($urandom_range(0, 95) * 2) + 32'($urandom_range(0, 1));
            mode = ($urandom_range(0, 9) == 0) ? 1 : ($urandom_range(0, 9) == 0) ? 2 : 0;
            fetch(a, mode);
        end

        do_flush();
        mc_enable = 1'b0;
        @(negedge clk_in);
        IF_query_addr = 32'h0000_4000;
        IF_query_en   = 1'b1;
        @(negedge clk_in);
        check("t6_req", {31'd0, MC_query_en}, 32'd1);
        check("t6_addr", MC_query_addr, 32'h0000_4000);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        @(negedge clk_in);
        check("t6_mc_en", {31'd0, MC_query_en}, 32'd0);
        check("t6_mc_addr", MC_query_addr, 32'd0);
        check("t6_if_en", {31'd0, IF_dout_en}, 32'd0);
        check("t6_if_dout", IF_dout, 32'd0);
        rst_n_in    = 1'b1;
        IF_query_en = 1'b0;
        @(negedge clk_in);
        check("t6_idle", {31'd0, MC_query_en}, 32'd0);
        model_clear();
        mc_enable = 1'b1;
        fetch(32'h0000_4000, 0);
        fetch(32'h0000_4002, 0);

        repeat (5) @(negedge clk_in);
        check("resp_drained", resp_q.size(), 32'd0);
        check("mc_drained", mc_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
